// File: rtl/hcsr04_pkg.sv
// Shared types and default constants for the HC-SR04 range-finder front end.
// The optional echo timeout is enabled with the HCSR04_TIMEOUT_EN macro.
package hcsr04_pkg;

    localparam int CYCLES_PER_CM_DEF  = 2941;
    localparam int TRIGGER_CYCLES_DEF = 500;
    localparam int TIMEOUT_CYCLES_DEF = 3_000_000;
    localparam int BCD_DIGIT_W        = 4;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECHO   = 4'h3,
        MEDE          = 4'h4,
        ARMAZENA      = 4'h5,
        ERRO          = 4'hE,
        FINAL         = 4'hF
    } estado_t;

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit packed BCD counter with synchronous clear and enable.
// Saturates at 999 instead of wrapping so an over-range echo reads as 999 cm.
module contador_bcd_3dig
    import hcsr04_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     enable_i,
    output logic [3*BCD_DIGIT_W-1:0] count_o
);

    logic [3*BCD_DIGIT_W-1:0] count_q, count_d;
    logic [BCD_DIGIT_W-1:0]   uni, dez, cen;

    always_comb begin
        count_d = count_q;
        uni     = count_q[BCD_DIGIT_W-1:0];
        dez     = count_q[2*BCD_DIGIT_W-1:BCD_DIGIT_W];
        cen     = count_q[3*BCD_DIGIT_W-1:2*BCD_DIGIT_W];
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && count_q != 12'h999) begin
            if (uni == 4'd9) begin
                uni = 4'd0;
                if (dez == 4'd9) begin
                    dez = 4'd0;
                    cen = cen + 4'd1;
                end else begin
                    dez = dez + 4'd1;
                end
            end else begin
                uni = uni + 4'd1;
            end
            count_d = {cen, dez, uni};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 front end: trigger pulse, echo timing, BCD centimetre result for the serial transmitter.
// Define HCSR04_TIMEOUT_EN to abort a measurement when no echo completes in TIMEOUT_CYCLES.
module interface_hcsr04
    import hcsr04_pkg::*;
#(
    parameter int CYCLES_PER_CM  = CYCLES_PER_CM_DEF,
    parameter int TRIGGER_CYCLES = TRIGGER_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int CW = $clog2(CYCLES_PER_CM + 1);
    localparam int TW = $clog2(TRIGGER_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_CM - 1);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);

    estado_t       state_q, state_d;
    logic          echo_m_q, echo_s_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [TW-1:0] trig_q, trig_d;
    logic [11:0]   medida_q, medida_d;
    logic [11:0]   bcd_val;
    logic          bcd_clear, bcd_en;
    logic          timeout_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_m_q <= 1'b0;
            echo_s_q <= 1'b0;
        end else begin
            echo_m_q <= echo;
            echo_s_q <= echo_m_q;
        end
    end

    // Every MEDE cycle is counted, including the one that samples echo low,
    // so the counted cycles equal the synchronised echo width.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        trig_d    = trig_q;
        medida_d  = medida_q;
        bcd_clear = 1'b0;
        bcd_en    = 1'b0;
        trigger   = 1'b0;
        pronto    = 1'b0;
        case (state_q)
            INICIAL: if (medir) state_d = PREPARA;
            PREPARA: begin
                cyc_d     = '0;
                trig_d    = '0;
                bcd_clear = 1'b1;
                state_d   = ENVIA_TRIGGER;
            end
            ENVIA_TRIGGER: begin
                trigger = 1'b1;
                if (trig_q == TRIG_LAST) state_d = ESPERA_ECHO;
                else                     trig_d  = trig_q + TW'(1);
            end
            ESPERA_ECHO: begin
                if (echo_s_q)         state_d = MEDE;
                else if (timeout_hit) state_d = ERRO;
            end
            MEDE: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d  = '0;
                    bcd_en = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
                if (!echo_s_q)        state_d = ARMAZENA;
                else if (timeout_hit) state_d = ERRO;
            end
            ARMAZENA: begin
                medida_d = bcd_val;
                state_d  = FINAL;
            end
            ERRO:  state_d = FINAL;
            FINAL: begin
                pronto  = 1'b1;
                state_d = INICIAL;
            end
            default: state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INICIAL;
            cyc_q    <= '0;
            trig_q   <= '0;
            medida_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            trig_q   <= trig_d;
            medida_q <= medida_d;
        end
    end

`ifdef HCSR04_TIMEOUT_EN
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OW-1:0] TOUT_LAST = OW'(TIMEOUT_CYCLES - 1);

    logic [OW-1:0] tout_q, tout_d;
    logic          erro_q, erro_d;

    assign timeout_hit = (tout_q == TOUT_LAST);

    always_comb begin
        tout_d = tout_q;
        erro_d = erro_q;
        if (state_q == PREPARA) begin
            tout_d = '0;
            erro_d = 1'b0;
        end else if ((state_q == ESPERA_ECHO || state_q == MEDE) && !timeout_hit) begin
            tout_d = tout_q + OW'(1);
        end else if (state_q == ERRO) begin
            erro_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tout_q <= '0;
            erro_q <= 1'b0;
        end else begin
            tout_q <= tout_d;
            erro_q <= erro_d;
        end
    end

    assign erro = erro_q;
`else
    assign timeout_hit = 1'b0;
    assign erro        = 1'b0;
`endif

    contador_bcd_3dig u_bcd (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (bcd_clear),
        .enable_i (bcd_en),
        .count_o  (bcd_val)
    );

    assign medida    = medida_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Self-checking bench for interface_hcsr04 with a scaled-down CYCLES_PER_CM to keep runs short.
// Expected distances come from floor(width / CYCLES_PER_CM), clamped to 999, then split into decimal digits.
module tb_interface_hcsr04;

  localparam int CPC  = 7;
  localparam int TRIG = 500;
  localparam int TOUT = 20000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo  = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  st_seq[$];

  interface_hcsr04 #(
    .CYCLES_PER_CM  (CPC),
    .TRIGGER_CYCLES (TRIG),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model
  function automatic logic [11:0] ref_bcd(input int width);
    int d;
    d = width / CPC;
    if (d > 999) d = 999;
    return 12'((d / 100) * 256 + ((d / 10) % 10) * 16 + (d % 10));
  endfunction

  // driver tasks
  task automatic start_meas(output int trig_cnt, output bit reached);
    trig_cnt = 0;
    reached  = 0;
    st_seq.delete();
    @(negedge clock);
    st_seq.push_back(db_estado);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (st_seq[st_seq.size()-1] !== db_estado) st_seq.push_back(db_estado);
      if (db_estado == 4'h3) begin
        reached = 1;
        break;
      end
      if (trigger) trig_cnt++;
      @(negedge clock);
    end
  endtask

  task automatic pulse_echo(input int pre, input int width);
    repeat (pre) @(negedge clock);
    echo = 1'b1;
    repeat (width) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic wait_pronto(input logic [11:0] old, output logic [11:0] res,
                             output int pcount, output bit seen, output bit early);
    seen   = 0;
    early  = 0;
    pcount = 0;
    res    = 'x;
    for (int i = 0; i < 100; i++) begin
      if (pronto) begin
        seen = 1;
        res  = medida;
        break;
      end
      if (medida !== old) early = 1;
      @(negedge clock);
    end
    if (seen) begin
      @(negedge clock);
      pcount = pronto ? 2 : 1;
    end
  endtask

  task automatic measure(input int pre, input int width, output logic [11:0] res,
                         output int pcount, output bit seen, output bit early,
                         output int trig_cnt, output bit reached);
    logic [11:0] old;
    old = medida;
    start_meas(trig_cnt, reached);
    seen = 0; early = 0; pcount = 0; res = 'x;
    if (reached) begin
      pulse_echo(pre, width);
      wait_pronto(old, res, pcount, seen, early);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      echo = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (trigger !== 1'b0 || pronto !== 1'b0 || erro !== 1'b0 ||
          medida !== 12'h000 || db_estado !== 4'h0) begin
        errors++;
        $display("FAIL reset_state: trigger=%b pronto=%b erro=%b medida=%h db_estado=%h, expected 0 0 0 000 0",
                 trigger, pronto, erro, medida, db_estado);
      end
    end
    @(negedge clock);
    echo = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_trigger();
    int tc; bit rch, seen, early; int pc; logic [11:0] res; bit bad;
    start_meas(tc, rch);
    checks++;
    if (!rch) begin
      errors++;
      $display("FAIL trig_reach_wait: db_estado=%h, expected 3 within 2000 cycles", db_estado);
      return;
    end
    checks++;
    if (tc !== TRIG) begin
      errors++;
      $display("FAIL trig_width: got %0d cycles, expected %0d", tc, TRIG);
    end
    bad = (st_seq.size() != 4);
    for (int i = 0; i < st_seq.size() && i < 4; i++) if (st_seq[i] !== 4'(i)) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL state_seq: got %0d states (%h %h ...), expected 0 1 2 3",
               st_seq.size(), st_seq[0], st_seq[st_seq.size()-1]);
    end
    pulse_echo(2, 3 * CPC);
    wait_pronto(medida, res, pc, seen, early);
    checks++;
    if (!seen || res !== ref_bcd(3 * CPC) || pc != 1) begin
      errors++;
      $display("FAIL first_meas: seen=%0d medida=%h pronto_cycles=%0d, expected 1 %h 1",
               seen, res, pc, ref_bcd(3 * CPC));
    end
  endtask

  task automatic test_boundaries();
    int widths[4];
    int tc, pc; bit rch, seen, early; logic [11:0] res;
    widths = '{123 * CPC, CPC - 1, 1, 2 * CPC - 1};
    foreach (widths[k]) begin
      measure(1, widths[k], res, pc, seen, early, tc, rch);
      checks++;
      if (!rch || !seen || res !== ref_bcd(widths[k]) || pc != 1) begin
        errors++;
        $display("FAIL boundary_w%0d: reached=%0d seen=%0d medida=%h pronto_cycles=%0d, expected medida %h one-cycle pronto",
                 widths[k], rch, seen, res, pc, ref_bcd(widths[k]));
      end
    end
  endtask

  task automatic test_random();
    int w, pre, tc, pc; bit rch, seen, early; logic [11:0] res, exp_v;
    for (int i = 0; i < 6; i++) begin
      w   = $urandom_range(1, 300 * CPC);
      pre = $urandom_range(0, 5);
      exp_q.push_back(ref_bcd(w));
      measure(pre, w, res, pc, seen, early, tc, rch);
      exp_v = exp_q.pop_front();
      checks++;
      if (!rch || !seen || res !== exp_v || pc != 1 || erro !== 1'b0) begin
        errors++;
        $display("FAIL random_w%0d: seen=%0d medida=%h pronto_cycles=%0d erro=%b, expected %h 1-cycle erro=0",
                 w, seen, res, pc, erro, exp_v);
      end
      checks++;
      if (early) begin
        errors++;
        $display("FAIL medida_hold_w%0d: medida changed before pronto, expected stable", w);
      end
    end
  endtask

  task automatic test_saturation();
    int tc, pc; bit rch, seen, early; logic [11:0] res;
    measure(0, 1005 * CPC, res, pc, seen, early, tc, rch);
    checks++;
    if (!seen || res !== 12'h999) begin
      errors++;
      $display("FAIL saturation: seen=%0d medida=%h, expected 999", seen, res);
    end
  endtask

  task automatic test_timeout();
    int tc, cnt; bit rch, seen; logic [11:0] old;
    old = medida;
    start_meas(tc, rch);
    seen = 0;
    cnt  = 0;
`ifdef HCSR04_TIMEOUT_EN
    for (int i = 0; i < TOUT + 200; i++) begin
      if (pronto) begin
        seen = 1;
        break;
      end
      cnt++;
      @(negedge clock);
    end
    checks++;
    if (!seen || cnt < TOUT - 2 || cnt > TOUT + 5) begin
      errors++;
      $display("FAIL timeout_pronto: seen=%0d after %0d cycles, expected near %0d", seen, cnt, TOUT);
    end
    checks++;
    if (erro !== 1'b1 || medida !== old) begin
      errors++;
      $display("FAIL timeout_flags: erro=%b medida=%h, expected 1 %h", erro, medida, old);
    end
    begin
      int pc; bit rch2, early; logic [11:0] res;
      measure(1, 5 * CPC, res, pc, seen, early, tc, rch2);
      checks++;
      if (erro !== 1'b0 || res !== ref_bcd(5 * CPC)) begin
        errors++;
        $display("FAIL timeout_clear: erro=%b medida=%h, expected 0 %h", erro, res, ref_bcd(5 * CPC));
      end
    end
`else
    for (int i = 0; i < 3000; i++) begin
      if (pronto || db_estado !== 4'h3) seen = 1;
      if (!seen) cnt++;
      @(negedge clock);
    end
    checks++;
    if (!rch || seen || erro !== 1'b0 || medida !== old) begin
      errors++;
      $display("FAIL no_timeout_wait: db_estado=%h stayed %0d cycles erro=%b medida=%h, expected 3 for 3000 erro=0 %h",
               db_estado, cnt, erro, medida, old);
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
`endif
  endtask

  task automatic test_reset_mid();
    int tc, pc; bit rch, seen, early; logic [11:0] res;
    @(negedge clock); medir = 1'b1;
    @(negedge clock); medir = 1'b0;
    repeat (10) @(negedge clock);
    checks++;
    if (trigger !== 1'b1) begin
      errors++;
      $display("FAIL trig_active: trigger=%b, expected 1", trigger);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (trigger !== 1'b0 || db_estado !== 4'h0) begin
      errors++;
      $display("FAIL reset_in_trigger: trigger=%b db_estado=%h, expected 0 0", trigger, db_estado);
    end
    @(negedge clock); reset = 1'b1;
    measure(1, 10 * CPC, res, pc, seen, early, tc, rch);
    start_meas(tc, rch);
    pulse_echo(1, 50);
    checks++;
    if (db_estado !== 4'h4 || medida !== ref_bcd(10 * CPC)) begin
      errors++;
      $display("FAIL in_mede: db_estado=%h medida=%h, expected 4 %h", db_estado, medida, ref_bcd(10 * CPC));
    end
    echo  = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (db_estado !== 4'h0 || medida !== 12'h000 || trigger !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_mede: db_estado=%h medida=%h trigger=%b pronto=%b, expected 0 000 0 0",
               db_estado, medida, trigger, pronto);
    end
    @(negedge clock);
    echo  = 1'b0;
    reset = 1'b1;
    measure(2, 80 * CPC, res, pc, seen, early, tc, rch);
    checks++;
    if (!seen || res !== 12'h080) begin
      errors++;
      $display("FAIL after_reset_meas: seen=%0d medida=%h, expected 080", seen, res);
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_boundaries();
    test_random();
    test_saturation();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interface_hcsr04.md
# interface_hcsr04

Ultrasonic range-finder front end that sits directly upstream of the serial ASCII transmitter. On a `medir` request it emits the HC-SR04 trigger pulse, times the echo pulse, and converts the width to whole centimetres as three packed BCD digits. The result on `medida[11:0]` is the 12-bit word the transmitter serialises, and `pronto` tells the system controller to start transmission.

## Interface
- `CYCLES_PER_CM`, 2941: clock cycles of echo per centimetre (50 MHz, 58.82 µs/cm).
- `TRIGGER_CYCLES`, 500: trigger high width (10 µs).
- `TIMEOUT_CYCLES`, 3_000_000: echo timeout (60 ms), used only with the timeout feature.
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `medir`  input  1  start request, level-sampled in the idle state.
- `echo`  input  1  sensor echo, asynchronous to `clock`.
- `trigger`  output  1  sensor trigger pulse.
- `medida`  output  12  distance in cm, BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- `pronto`  output  1  one-cycle pulse when a measurement or timeout completes.
- `erro`  output  1  timeout flag for the last measurement.
- `db_estado`  output  4  current FSM state code.

## Operation
- `echo` passes through a 2-flop synchroniser. All decisions use the synchronised value `echo_s`.
- FSM states and codes:
  - INICIAL 0x0
  - PREPARA 0x1
  - ENVIA_TRIGGER 0x2
  - ESPERA_ECHO 0x3
  - MEDE 0x4
  - ARMAZENA 0x5
  - FINAL 0xF
  - ERRO 0xE
- INICIAL: when `medir`=1 -> PREPARA. `medir` is ignored in every other state.
- PREPARA: clear the cycle counter, the BCD counter and the timeout counter. Clear `erro`. -> ENVIA_TRIGGER.
- ENVIA_TRIGGER: `trigger`=1 for exactly TRIGGER_CYCLES cycles, then -> ESPERA_ECHO.
- ESPERA_ECHO: when `echo_s`=1 -> MEDE.
- MEDE: the cycle counter counts 0..CYCLES_PER_CM-1. On wrap it increments the BCD counter with decimal carry. When `echo_s`=0 -> ARMAZENA.
- Distance is floor(echo_cycles / CYCLES_PER_CM). Partial centimetres are discarded.
- The BCD counter saturates at 0x999. It never wraps to 0x000.
- ARMAZENA: load the BCD count into the `medida` register -> FINAL.
- FINAL: `pronto`=1 for one cycle -> INICIAL.
- `medida` holds its value until the next ARMAZENA. It never changes during a measurement.
- Reset (`reset`=0, asynchronous) values:
  - state INICIAL
  - `trigger`=0, `pronto`=0, `erro`=0
  - `medida`=0x000
  - `db_estado`=0x0
  - all counters and synchroniser flops 0
- Reset asserted mid-operation aborts immediately. `trigger` drops in the same instant, with no partial result.

## Timing
- `medir` high at edge N puts the FSM in PREPARA after N. `trigger` is high from the edge after PREPARA for TRIGGER_CYCLES cycles.
- Synchroniser latency: 2 cycles from a raw `echo` edge to `echo_s`. Measured width equals raw width to within ±1 cycle.
- After `echo_s` falls, the sequence is MEDE -> ARMAZENA -> FINAL:
  - `medida` is valid on the cycle `pronto` is high.
  - `pronto` rises 2 cycles after the edge that samples `echo_s`=0.
- If `echo_s` rises and falls on consecutive cycles, MEDE lasts one cycle and the result is 0x000.
- If `echo` is already high in ESPERA_ECHO (a stale echo), the FSM measures from that point. No edge detection is required.

## Configuration
- `HCSR04_TIMEOUT_EN` defined:
  - A timeout counter runs in ESPERA_ECHO and MEDE.
  - On reaching TIMEOUT_CYCLES it -> ERRO: `erro`=1, `medida` unchanged.
  - ERRO -> FINAL, which gives the `pronto` pulse.
  - `erro` holds until the next PREPARA.
- `HCSR04_TIMEOUT_EN` not defined:
  - No timeout logic. ESPERA_ECHO and MEDE wait indefinitely.
  - `erro` is tied to 0 and the ERRO state is never entered.

## Structure
- Package `hcsr04_pkg` holds:
  - the state enum with the codes above
  - default constants for CYCLES_PER_CM, TRIGGER_CYCLES and TIMEOUT_CYCLES
  - the BCD digit width (4)
- Sub-module `contador_bcd_3dig`: 3-digit saturating BCD counter with clear and enable, a 12-bit output, and the same clock and reset.
- The FSM, cycle counter, trigger counter, timeout counter, synchroniser and `medida` register live in `interface_hcsr04`.

## Test plan
- Reset asserted with random `echo` activity -> `trigger`=0, `pronto`=0, `erro`=0, `medida`=0x000, `db_estado`=0x0.
- `medir` pulse -> `trigger` high for exactly 500 cycles. `db_estado` steps through 0x0, 0x1, 0x2, 0x3.
- Echo width of 123×2941 cycles -> `medida`=0x123 with a one-cycle `pronto`. Echo width of 2940 cycles -> `medida`=0x000.
- Echo width of 1005×2941 cycles, with TIMEOUT_CYCLES raised above that -> `medida`=0x999 (saturation, no wrap).
- With `HCSR04_TIMEOUT_EN`, no echo -> after 3_000_000 cycles `erro`=1, `pronto` pulses and `medida` keeps its previous value. Without the macro -> FSM stays at 0x3.
- Reset asserted mid-MEDE -> immediate return to INICIAL with `medida`=0x000. The next `medir` with an 80×2941-cycle echo -> `medida`=0x080.
